// File: rtl/alu_arb_seq.sv
// Two-requester round-robin front end for one shared 8-bit ALU.
// A granted request is either issued to the ALU for WAIT_CYC cycles and then
// captured, or, for an illegal opcode, answered at once with an error response.
// Only one operation is in flight at a time.
module alu_arb_seq #(
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  // Counter starts at WAIT_CYC-1 so ISSUE lasts exactly WAIT_CYC cycles.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic        rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_cout_q, rsp_cout_d;
  logic        rsp_err_q, rsp_err_d;

  logic        gnt_vld;
  logic        gnt_idx;
  logic        accept;
  logic [7:0]  acc_a;
  logic [7:0]  acc_b;
  logic [3:0]  acc_sel;
  logic        acc_legal;

  // Round-robin grant: the pointer only breaks ties when both requesters are valid.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    case (req_valid)
      2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;  end
      2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;  end
      2'b11:   begin gnt_vld = 1'b1; gnt_idx = ptr_q; end
      default: begin gnt_vld = 1'b0; gnt_idx = ptr_q; end
    endcase
  end

  assign accept    = (state_q == IDLE) && gnt_vld;
  assign req_ready = accept ? (2'b01 << gnt_idx) : 2'b00;

  // Only the granted requester's fields reach the state logic.
  assign acc_a     = gnt_idx ? req_a[15:8]  : req_a[7:0];
  assign acc_b     = gnt_idx ? req_b[15:8]  : req_b[7:0];
  assign acc_sel   = gnt_idx ? req_sel[7:4] : req_sel[3:0];
  // Illegal opcodes are exactly the odd codes above 1000 (1001, 1011, 1101, 1111).
  assign acc_legal = !(acc_sel[3] && acc_sel[0]);

  // Next-state and datapath-load logic; every register holds unless told otherwise.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d    = ~gnt_idx;
          rsp_id_d = gnt_idx;
          if (acc_legal) begin
            alu_a_d   = acc_a;
            alu_b_d   = acc_b;
            alu_sel_d = acc_sel;
            cnt_d     = CNT_INIT;
            state_d   = ISSUE;
          end else begin
            // ALU ports keep the previous operation; answer with an error.
            rsp_data_d = 8'h00;
            rsp_cout_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        rsp_data_d = alu_out;
        rsp_cout_d = alu_cout;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= 4'd0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_sel_q  <= 4'h0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb_seq.sv
// Bench for alu_arb_seq: three instances (WAIT_CYC = 1, 4, 15) each driven by
// its own directed + random stimulus, with a queue of expected responses
// consumed by an independent response monitor.
module tb_alu_arb_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] done = 3'b000;

  task automatic check(input string nm, input int w, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s (WAIT_CYC=%0d) t=%0t: got 0x%0h, expected 0x%0h", nm, w, $time, act, expv);
  endtask

  // Reference ALU: subtract with "no borrow" carry for opcode 0, else a+b+opcode.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    if (s == 4'd0) return {a >= b, a - b};
    return {1'b0, a} + {1'b0, b} + 9'(s);
  endfunction

  // Legal opcodes: 0..8 plus the even codes above 8.
  function automatic logic legal_fn(input logic [3:0] s);
    return (int'(s) <= 8) || (int'(s) % 2 == 0);
  endfunction

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       cout;
    logic       err;
    int         t0;
    int         lat;
  } exp_t;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 4 : 15);

    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [7:0]  req_sel;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_cout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err, busy;
    logic [7:0]  rsp_data;

    int   cyc = 0;
    exp_t sb[$];
    exp_t cur;
    logic in_resp = 1'b0;
    logic idle_next = 1'b0;
    logic rr;                  // model: whose turn on a tie
    logic [7:0] ea, eb;        // model: last issued ALU operands
    logic [3:0] es;
    logic acc;
    logic just_acc;

    always @(posedge clk) cyc <= cyc + 1;
    always_comb {alu_cout, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

    alu_arb_seq #(.WAIT_CYC(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy)
    );

    // One clock: check grant and ALU ports at the falling edge, record any
    // handshake into the scoreboard, then return just after the rising edge.
    task automatic step();
      logic [1:0] g;
      logic i;
      logic [3:0] s;
      logic [7:0] a, b;
      logic [8:0] r;
      exp_t e;
      @(negedge clk);
      acc = 1'b0;
      check("alu_ports", W, {alu_a, alu_b, alu_sel}, {ea, eb, es});
      if (just_acc) check("busy_after_accept", W, busy, 1'b1);
      just_acc = 1'b0;
      if (!busy) begin
        if (req_valid == 2'b11) g = rr ? 2'b10 : 2'b01;
        else g = req_valid;
        check("req_ready", W, req_ready, g);
      end else begin
        check("req_ready_busy", W, req_ready, 2'b00);
      end
      if ((req_valid & req_ready) != 2'b00) begin
        i = req_ready[1];
        a = i ? req_a[15:8]  : req_a[7:0];
        b = i ? req_b[15:8]  : req_b[7:0];
        s = i ? req_sel[7:4] : req_sel[3:0];
        e.id = i;
        e.t0 = cyc;
        if (legal_fn(s)) begin
          r = alu_fn(a, b, s);
          e.data = r[7:0]; e.cout = r[8]; e.err = 1'b0; e.lat = W + 2;
          ea = a; eb = b; es = s;
        end else begin
          e.data = 8'h00; e.cout = 1'b0; e.err = 1'b1; e.lat = 1;
        end
        sb.push_back(e);
        rr = ~i;
        acc = 1'b1;
        just_acc = 1'b1;
      end
      @(posedge clk);
      #1;
    endtask

    task automatic wait_acc();
      acc = 1'b0;
      for (int k = 0; k < 60 && !acc; k++) step();
      check("accept_seen", W, acc, 1'b1);
    endtask

    // Response monitor: pops expectations when a new response appears and
    // checks it stays put until it is taken.
    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          in_resp = 1'b0;
          idle_next = 1'b0;
        end else begin
          if (idle_next) begin
            check("busy_after_rsp", W, busy, 1'b0);
            idle_next = 1'b0;
          end
          if (rsp_valid) begin
            if (!in_resp) begin
              if (sb.size() == 0) begin
                check("rsp_unexpected", W, rsp_valid, 1'b0);
              end else begin
                cur = sb.pop_front();
                in_resp = 1'b1;
                check("latency", W, cyc - cur.t0, cur.lat);
              end
            end
            if (in_resp) begin
              check("rsp_fields", W, {rsp_id, rsp_data, rsp_cout, rsp_err},
                    {cur.id, cur.data, cur.cout, cur.err});
              check("busy_in_resp", W, busy, 1'b1);
              if (rsp_ready) begin
                in_resp = 1'b0;
                idle_next = 1'b1;
              end
            end
          end
        end
      end
    end

    // Stimulus.
    initial begin
      rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
      rr = 1'b0; ea = '0; eb = '0; es = '0; acc = 1'b0; just_acc = 1'b0;
      #2;
      check("reset_alu", W, {alu_a, alu_b, alu_sel}, 20'h0);
      check("reset_ctl", W, {req_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, busy}, 15'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single legal op from requester 0: 0x0F - 0x01 = 0x0E, no borrow.
      rsp_ready = 1'b1;
      req_valid = 2'b01; req_a = 16'hAA0F; req_b = 16'h5501; req_sel = 8'hB0;
      wait_acc();
      req_valid = 2'b00;
      repeat (W + 4) step();

      // Illegal opcode 1011 from requester 1: ALU ports must not move.
      req_valid = 2'b10; req_a = 16'h3377; req_b = 16'h4488; req_sel = 8'hB2;
      wait_acc();
      req_valid = 2'b00;
      repeat (4) step();

      // Contention: both valid, consumer always ready; grants alternate.
      req_valid = 2'b11;
      repeat (6 * (W + 4)) begin
        req_a = 16'($urandom); req_b = 16'($urandom); req_sel = 8'($urandom);
        step();
      end
      req_valid = 2'b00;
      repeat (W + 4) step();

      // Backpressure: hold the response for several cycles.
      req_valid = 2'b01; req_a = 16'h0091; req_b = 16'h0023; req_sel = 8'h02;
      wait_acc();
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      repeat (W + 8) step();
      rsp_ready = 1'b1;
      repeat (2) step();

      // Random traffic with random consumer stalls.
      repeat (150) begin
        req_valid = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
        req_sel = 8'($urandom); rsp_ready = ($urandom_range(0, 2) != 0);
        step();
      end
      req_valid = 2'b00; rsp_ready = 1'b1;
      repeat (W + 6) step();

      // Reset while an operation is in ISSUE.
      req_valid = 2'b01; req_a = 16'h0012; req_b = 16'h0034; req_sel = 8'h03;
      wait_acc();
      req_valid = 2'b00;
      repeat ((W > 1) ? 1 : 0) step();
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_alu", W, {alu_a, alu_b, alu_sel}, 20'h0);
      check("async_reset_ctl", W, {req_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, busy}, 15'h0);
      sb.delete();
      rr = 1'b0; ea = '0; eb = '0; es = '0; just_acc = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (W + 4) step();   // any response here is flagged as unexpected

      // First tie after reset goes to requester 0, then keep alternating.
      req_valid = 2'b11;
      repeat (3 * (W + 4)) begin
        req_a = 16'($urandom); req_b = 16'($urandom); req_sel = 8'($urandom);
        step();
      end
      req_valid = 2'b00;
      repeat (W + 6) step();

      check("scoreboard_drained", W, sb.size(), 0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && !(&done); k++) @(posedge clk);
    if (!(&done)) check("run_timeout", 0, {29'h0, done}, 32'h7);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
